// File: rtl/subtractor32_pipe_pkg.sv
// Shared constants and stage record for the byte-sliced add/sub pipelines.
// Each record carries its operands, the partial result and the running borrow.
package subtractor32_pipe_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int SLICE_DEF = 8;
   localparam int TAG_W_DEF = 8;
   localparam int NST       = WIDTH_DEF / SLICE_DEF;

   typedef struct packed {
      logic                 valid;
      logic [TAG_W_DEF-1:0] tag;
      logic [WIDTH_DEF-1:0] a;
      logic [WIDTH_DEF-1:0] b;
      logic [WIDTH_DEF-1:0] d;
      logic                 bo;
      logic                 a_sgn;
      logic                 b_sgn;
   } stage_t;

endpackage

// File: rtl/sub_slice.sv
// Combinational SLICE-bit subtract with borrow-in and borrow-out.
// Computes {bo, d} = a - b - bi.
module sub_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             bi,
   output logic [SLICE-1:0] d,
   output logic             bo
);

   logic [SLICE:0] diff;

   always_comb begin
      diff = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bi};
      d    = diff[SLICE-1:0];
      bo   = diff[SLICE];
   end

endmodule

// File: rtl/subtractor32_pipe.sv
// Pipelined signed subtractor: one input capture stage, then one slice
// of the borrow chain resolved per register stage.
module subtractor32_pipe
   import subtractor32_pipe_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SLICE = SLICE_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inpA,
   input  logic [WIDTH-1:0] inpB,
   input  logic [TAG_W-1:0] X_In,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] outD,
   output logic [TAG_W-1:0] xout,
   output logic             ovf,
   output logic             borrow
);

   localparam int NS = WIDTH / SLICE;

   stage_t st_q [NS+1];
   stage_t st_d [NS+1];
   stage_t fin;

   logic [SLICE-1:0] d_w  [NS];
   logic             bo_w [NS];
   logic             adv;

   for (genvar k = 0; k < NS; k++) begin : g_slice
      sub_slice #(.SLICE(SLICE)) u_slice (
         .a  (st_q[k].a[k*SLICE +: SLICE]),
         .b  (st_q[k].b[k*SLICE +: SLICE]),
         .bi (st_q[k].bo),
         .d  (d_w[k]),
         .bo (bo_w[k])
      );
   end

   assign fin       = st_q[NS];
   assign adv       = !fin.valid || out_ready;
   assign in_ready  = adv && reset;
   assign out_valid = fin.valid;
   assign outD      = fin.d;
   assign xout      = fin.tag;
   assign borrow    = fin.bo;
   assign ovf       = (fin.a_sgn != fin.b_sgn) &&
                      (fin.d[WIDTH-1] != fin.a_sgn);

   always_comb begin
      st_d = st_q;
      if (adv) begin
         st_d[0]       = '0;
         st_d[0].valid = in_valid;
         st_d[0].tag   = X_In;
         st_d[0].a     = inpA;
         st_d[0].b     = inpB;
         st_d[0].a_sgn = inpA[WIDTH-1];
         st_d[0].b_sgn = inpB[WIDTH-1];
         // stage 0 borrow stays 0, so slice 0 sees bi=0
         for (int k = 0; k < NS; k++) begin
            st_d[k+1]                    = st_q[k];
            st_d[k+1].d[k*SLICE +: SLICE] = d_w[k];
            st_d[k+1].bo                 = bo_w[k];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) st_q <= '{default: '0};
      else        st_q <= st_d;
   end

endmodule

// File: tb/tb_subtractor32_pipe.sv
// Directed self-checking bench for subtractor32_pipe.
module tb_subtractor32_pipe;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] inpA;
   logic [31:0] inpB;
   logic [7:0]  X_In;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] outD;
   logic [7:0]  xout;
   logic        ovf;
   logic        borrow;

   int n_chk = 0;
   int n_err = 0;

   subtractor32_pipe dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inpA      (inpA),
      .inpB      (inpB),
      .X_In      (X_In),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .outD      (outD),
      .xout      (xout),
      .ovf       (ovf),
      .borrow    (borrow)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [7:0] t);
      in_valid = v;
      inpA     = a;
      inpB     = b;
      X_In     = t;
   endtask

   // back-to-back vectors: A, B, D, borrow, ovf
   int   va [7] = '{9943121, -3686, 2, 0,
                    32'h80000000, 32'h7FFFFFFF, -1};
   int   vb [7] = '{-3302367, 3023, 2, 1, 1, -1, -1};
   int   vd [7] = '{13245488, -6709, 0, -1,
                    32'h7FFFFFFF, 32'h80000000, 0};
   logic vbo [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic vov [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   // backpressure vectors
   int   pa [4] = '{10, 20, 30, 32'h7FFFFFF0};
   int   pb [4] = '{3, 5, 40, 32'h10};
   int   pd [4] = '{7, 15, -10, 32'h7FFFFFE0};
   logic pbo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      logic [31:0] e;
      reset     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, '0, '0, '0);

      tick();
      check("rst_in_ready", in_ready, 1'b0);
      tick();
      check("rst_out_valid", out_valid, 1'b0);
      reset = 1'b1;
      #1;
      check("rel_in_ready", in_ready, 1'b1);
      tick();
      check("rel_out_valid", out_valid, 1'b0);
      check("rel_outD", outD, 32'h0);
      check("rel_xout", xout, 8'h0);

      // single item, 4-edge latency
      drive(1'b1, 32'd36865, 32'd33023, 8'h6B);
      tick();
      drive(1'b0, '0, '0, '0);
      for (int i = 1; i < 4; i++) begin
         tick();
         check("lat_early_valid", out_valid, 1'b0);
      end
      tick();
      check("single_valid", out_valid, 1'b1);
      check("single_outD", outD, 32'd3842);
      check("single_xout", xout, 8'h6B);
      check("single_flags", {ovf, borrow}, 2'b00);
      tick();
      check("single_gone", out_valid, 1'b0);

      // back-to-back stream including overflow corners
      for (int c = 0; c < 11; c++) begin
         if (c < 7) drive(1'b1, va[c], vb[c], 8'h10 + 8'(c));
         else       drive(1'b0, '0, '0, '0);
         tick();
         if (c >= 4) begin
            e = vd[c-4];
            check("b2b_outD", outD, e);
            check("b2b_ctl", {out_valid, xout, ovf, borrow},
                  {1'b1, 8'h10 + 8'(c-4), vov[c-4], vbo[c-4]});
         end
      end
      tick();
      check("b2b_drained", out_valid, 1'b0);

      // backpressure with 4 items in flight
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, pa[c], pb[c], 8'h20 + 8'(c));
         tick();
      end
      drive(1'b0, '0, '0, '0);
      tick();
      e = pd[0];
      check("bp_first_outD", outD, e);
      out_ready = 1'b0;
      drive(1'b1, 32'hDEAD, 32'hBEEF, 8'hEE);
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      for (int s = 0; s < 3; s++) begin
         tick();
         check("bp_hold_ready", in_ready, 1'b0);
         check("bp_hold_outD", outD, e);
         check("bp_hold_ctl", {out_valid, xout, borrow},
               {1'b1, 8'h20, pbo[0]});
      end
      drive(1'b0, '0, '0, '0);
      out_ready = 1'b1;
      for (int c = 1; c < 4; c++) begin
         tick();
         e = pd[c];
         check("bp_rel_outD", outD, e);
         check("bp_rel_ctl", {out_valid, xout, borrow},
               {1'b1, 8'h20 + 8'(c), pbo[c]});
      end
      tick();
      check("bp_no_dup", out_valid, 1'b0);

      // reset with 3 items in flight
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 32'd100 + c, 32'd1, 8'h30 + 8'(c));
         tick();
      end
      drive(1'b0, '0, '0, '0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mid_rst_valid", out_valid, 1'b0);
      for (int c = 0; c < 6; c++) begin
         tick();
         check("mid_rst_flushed", out_valid, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
